temporizador_fase: RTL and testbench



---
 rtl/irrig_pkg.sv | 35 +++
 rtl/contador_bcd2.sv | 48 ++++
 rtl/temporizador_fase.sv | 123 ++++++++++++
 tb/tb_temporizador_fase.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/irrig_pkg.sv
// Shared definitions for the irrigation controller: state encodings,
// phase-timer FSM states and duration/BCD helpers.
package irrig_pkg;

  localparam logic [1:0] ASP  = 2'b00;
  localparam logic [1:0] GOT  = 2'b01;
  localparam logic [1:0] LIMP = 2'b10;
  localparam logic [1:0] ENCH = 2'b11;

  typedef enum logic {
    CONTANDO = 1'b0,
    EXPIRADO = 1'b1
  } fase_t;

  // Durations are passed in so each timer instance can use its own parameters.
  function automatic logic [6:0] dur_of(input logic [1:0] est,
                                        input logic [6:0] tAsp,
                                        input logic [6:0] tGot,
                                        input logic [6:0] tLimp,
                                        input logic [6:0] tEnch);
    logic [6:0] d;
    case (est)
      ASP:     d = tAsp;
      GOT:     d = tGot;
      LIMP:    d = tLimp;
      default: d = tEnch;
    endcase
    return d;
  endfunction

  function automatic logic [7:0] to_bcd(input logic [6:0] v);
    return {4'(v / 7'd10), 4'(v % 7'd10)};
  endfunction

endpackage

// File: rtl/contador_bcd2.sv
// Two-digit BCD down-counter with parallel load, decrement enable and a
// zero flag; it saturates at 00.
module contador_bcd2 #(
  parameter logic [7:0] RST_VAL = 8'h30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] loadVal,
  input  logic       dec,
  output logic [3:0] dezena,
  output logic [3:0] unidade,
  output logic       zero
);

  logic [3:0] dez_q, dez_d;
  logic [3:0] uni_q, uni_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dez_q <= RST_VAL[7:4];
      uni_q <= RST_VAL[3:0];
    end else begin
      dez_q <= dez_d;
      uni_q <= uni_d;
    end
  end

  always_comb begin
    dez_d = dez_q;
    uni_d = uni_q;
    if (load) begin
      {dez_d, uni_d} = loadVal;
    end else if (dec && !zero) begin
      if (uni_q == 4'd0) begin
        uni_d = 4'd9;
        dez_d = dez_q - 4'd1;
      end else begin
        uni_d = uni_q - 4'd1;
      end
    end
  end

  assign zero    = (dez_q == 4'd0) && (uni_q == 4'd0);
  assign dezena  = dez_q;
  assign unidade = uni_q;

endmodule

// File: rtl/temporizador_fase.sv
// Phase timer for the irrigation state machine: times the active phase,
// emits end-of-phase (sinal) and 15-second (sinalquinze) pulses and drives BCD digits.
module temporizador_fase
  import irrig_pkg::*;
#(
  parameter int CLK_DIV = 50000000,
  parameter int T_ASP   = 30,
  parameter int T_GOT   = 60,
  parameter int T_LIMP  = 10,
  parameter int T_ENCH  = 20,
  parameter int T_Q     = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] estado,
  input  logic       limpa,
  output logic       sinal,
  output logic       sinalquinze,
  output logic       expirado,
  output logic [3:0] dezena,
  output logic [3:0] unidade
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  if (CLK_DIV < 2 || T_ASP < 1 || T_ASP > 99 || T_GOT < 1 || T_GOT > 99 ||
      T_LIMP < 1 || T_LIMP > 99 || T_ENCH < 1 || T_ENCH > 99 ||
      T_Q < 1 || T_Q > 99) begin : g_param_check
    $error("temporizador_fase: durations must be 1..99 and CLK_DIV >= 2");
  end

  logic [1:0]    estadoAnt_q;
  logic [PW-1:0] presc_q, presc_d;
  logic [6:0]    elapsed_q, elapsed_d;
  fase_t         fase_q, fase_d;
  logic          sinal_q, sinal_d;
  logic          quinze_q, quinze_d;

  logic          restart;
  logic          tick;
  logic          countEn;
  logic          fimFase;
  logic          quinzeOk;
  logic          digZero;
  logic [6:0]    durAtual;
  logic [7:0]    loadBcd;

  assign restart  = limpa || (estado != estadoAnt_q);
  assign tick     = (presc_q == PW'(CLK_DIV - 1));
  assign durAtual = dur_of(estadoAnt_q, 7'(T_ASP), 7'(T_GOT), 7'(T_LIMP), 7'(T_ENCH));
  assign loadBcd  = to_bcd(dur_of(estado, 7'(T_ASP), 7'(T_GOT), 7'(T_LIMP), 7'(T_ENCH)));
  // When T_Q lands on the tick just before the final one, only sinal is wanted.
  assign quinzeOk = (durAtual > 7'(T_Q + 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fase_q <= CONTANDO;
    end else begin
      fase_q <= fase_d;
    end
  end

  always_comb begin
    fase_d = fase_q;
    case (fase_q)
      CONTANDO: if (fimFase) fase_d = EXPIRADO;
      EXPIRADO: fase_d = EXPIRADO;
      default:  fase_d = CONTANDO;
    endcase
    if (restart) fase_d = CONTANDO;
  end

  always_comb begin
    countEn  = (fase_q == CONTANDO) && tick && !restart && !digZero;
    fimFase  = countEn && (elapsed_q == durAtual - 7'd1);
    sinal_d  = fimFase;
    quinze_d = countEn && quinzeOk && ((elapsed_q + 7'd1) == 7'(T_Q));
    expirado = (fase_q == EXPIRADO);
  end

  always_comb begin
    presc_d   = (restart || tick) ? '0 : presc_q + PW'(1);
    elapsed_d = elapsed_q;
    if (restart) begin
      elapsed_d = '0;
    end else if (countEn) begin
      elapsed_d = elapsed_q + 7'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estadoAnt_q <= ASP;
      presc_q     <= '0;
      elapsed_q   <= '0;
      sinal_q     <= 1'b0;
      quinze_q    <= 1'b0;
    end else begin
      estadoAnt_q <= estado;
      presc_q     <= presc_d;
      elapsed_q   <= elapsed_d;
      sinal_q     <= sinal_d;
      quinze_q    <= quinze_d;
    end
  end

  contador_bcd2 #(
    .RST_VAL(to_bcd(7'(T_ASP)))
  ) u_digitos (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (restart),
    .loadVal (loadBcd),
    .dec     (countEn),
    .dezena  (dezena),
    .unidade (unidade),
    .zero    (digZero)
  );

  assign sinal       = sinal_q;
  assign sinalquinze = quinze_q;

endmodule

// File: tb/tb_temporizador_fase.sv
// Scoreboard bench for temporizador_fase: stimulus queues expected pulses and
// timed output snapshots, a negedge monitor pops and compares them.
module tb_temporizador_fase;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] estado;
  logic       limpa;
  logic       sinal;
  logic       sinalquinze;
  logic       expirado;
  logic [3:0] dezena;
  logic [3:0] unidade;

  always #5 clk = ~clk;

  temporizador_fase #(
    .CLK_DIV (4),
    .T_ASP   (30),
    .T_GOT   (60),
    .T_LIMP  (10),
    .T_ENCH  (16),
    .T_Q     (15)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .estado      (estado),
    .limpa       (limpa),
    .sinal       (sinal),
    .sinalquinze (sinalquinze),
    .expirado    (expirado),
    .dezena      (dezena),
    .unidade     (unidade)
  );

  typedef struct {
    int          cyc;
    bit          inRst;
    int          tag;
    logic [10:0] expv;
  } probe_t;

  typedef struct {
    int         cyc;
    bit         isSinal;
    logic [7:0] digits;
  } evt_t;

  probe_t probeQ[$];
  evt_t   evtQ[$];
  probe_t curP;
  evt_t   curE;
  int     cyc;
  int     checks = 0;
  int     errors = 0;
  int     probeTag = 0;
  bit     endReq = 1'b0;

  // Edge counter since the most recent reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic addProbe(input int c, input bit r, input logic s, input logic q,
                          input logic e, input logic [3:0] dz, input logic [3:0] un);
    probe_t p;
    p.cyc   = c;
    p.inRst = r;
    p.tag   = probeTag;
    p.expv  = {s, q, e, dz, un};
    probeTag++;
    probeQ.push_back(p);
  endtask

  task automatic addEvent(input int c, input bit isS, input logic [3:0] dz, input logic [3:0] un);
    evt_t ev;
    ev.cyc     = c;
    ev.isSinal = isS;
    ev.digits  = {dz, un};
    evtQ.push_back(ev);
  endtask

  task automatic applyStimulus(input logic [1:0] est, input logic lim);
    estado = est;
    limpa  = lim;
  endtask

  task automatic applyReset(input int nEdges);
    rst_n  = 1'b0;
    estado = 2'b00;
    limpa  = 1'b0;
    repeat (nEdges) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic waitCyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string name, input int tag,
                             input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s #%0d at cyc %0d: actual=%0h expected=%0h",
               name, tag, cyc, actual, expected);
    end
  endtask

  task automatic popEvent(input bit isS);
    if (evtQ.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL unexpected_%s at cyc %0d: actual=1 expected=0",
               isS ? "sinal" : "sinalquinze", cyc);
    end else begin
      curE = evtQ.pop_front();
      checkOutput("evt_kind", curE.cyc, 32'(isS), 32'(curE.isSinal));
      checkOutput("evt_cycle", curE.cyc, cyc, curE.cyc);
      checkOutput("evt_digits", curE.cyc, {24'd0, dezena, unidade}, {24'd0, curE.digits});
    end
  endtask

  // Monitor: sole owner of the check counters.
  always @(negedge clk) begin
    if (sinal)       popEvent(1'b1);
    if (sinalquinze) popEvent(1'b0);
    if (probeQ.size() > 0) begin
      curP = probeQ[0];
      if (curP.inRst ? !rst_n : (rst_n && cyc == curP.cyc)) begin
        checkOutput(curP.inRst ? "probe_reset" : "probe",
                    curP.tag,
                    {21'd0, sinal, sinalquinze, expirado, dezena, unidade},
                    {21'd0, curP.expv});
        void'(probeQ.pop_front());
      end else if (!curP.inRst && rst_n && cyc > curP.cyc) begin
        checkOutput("probe_missed", curP.tag, cyc, curP.cyc);
        void'(probeQ.pop_front());
      end
    end
    if (endReq) begin
      checkOutput("probe_leftover", 0, probeQ.size(), 0);
      checkOutput("event_leftover", 0, evtQ.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation did not complete, actual=timeout expected=done");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n  = 1'b0;
    estado = 2'b00;
    limpa  = 1'b0;

    // Default phase 00 held: 30 s, quinze at tick 15, then EXPIRADO.
    addProbe(0,   1, 0, 0, 0, 4'd3, 4'd0);
    addProbe(3,   0, 0, 0, 0, 4'd3, 4'd0);
    addProbe(4,   0, 0, 0, 0, 4'd2, 4'd9);
    addProbe(60,  0, 0, 1, 0, 4'd1, 4'd5);
    addProbe(61,  0, 0, 0, 0, 4'd1, 4'd5);
    addProbe(119, 0, 0, 0, 0, 4'd0, 4'd1);
    addProbe(120, 0, 1, 0, 1, 4'd0, 4'd0);
    addProbe(130, 0, 0, 0, 1, 4'd0, 4'd0);
    addEvent(60,  1'b0, 4'd1, 4'd5);
    addEvent(120, 1'b1, 4'd0, 4'd0);
    applyReset(2);
    waitCyc(131);

    // Phase change 00 -> 01 at edge 50.
    addProbe(0,   1, 0, 0, 0, 4'd3, 4'd0);
    addProbe(48,  0, 0, 0, 0, 4'd1, 4'd8);
    addProbe(50,  0, 0, 0, 0, 4'd6, 4'd0);
    addProbe(54,  0, 0, 0, 0, 4'd5, 4'd9);
    addProbe(110, 0, 0, 1, 0, 4'd4, 4'd5);
    addProbe(290, 0, 1, 0, 1, 4'd0, 4'd0);
    addProbe(292, 0, 0, 0, 1, 4'd0, 4'd0);
    addEvent(110, 1'b0, 4'd4, 4'd5);
    addEvent(290, 1'b1, 4'd0, 4'd0);
    applyReset(2);
    waitCyc(49);
    applyStimulus(2'b01, 1'b0);
    waitCyc(293);

    // Phase 10 with limpa at elapsed 7, then estado change on the final tick,
    // then a 16 s phase 11 where sinalquinze must stay silent.
    addProbe(0,   1, 0, 0, 0, 4'd3, 4'd0);
    addProbe(1,   0, 0, 0, 0, 4'd1, 4'd0);
    addProbe(29,  0, 0, 0, 0, 4'd0, 4'd3);
    addProbe(31,  0, 0, 0, 0, 4'd1, 4'd0);
    addProbe(41,  0, 0, 0, 0, 4'd0, 4'd8);
    addProbe(71,  0, 1, 0, 1, 4'd0, 4'd0);
    addProbe(80,  0, 0, 0, 0, 4'd1, 4'd0);
    addProbe(116, 0, 0, 0, 0, 4'd0, 4'd1);
    addProbe(120, 0, 0, 0, 0, 4'd1, 4'd6);
    addProbe(124, 0, 0, 0, 0, 4'd1, 4'd5);
    addProbe(180, 0, 0, 0, 0, 4'd0, 4'd1);
    addProbe(184, 0, 1, 0, 1, 4'd0, 4'd0);
    addProbe(186, 0, 0, 0, 1, 4'd0, 4'd0);
    addProbe(190, 0, 0, 0, 0, 4'd1, 4'd6);
    addProbe(218, 0, 0, 0, 0, 4'd0, 4'd9);
    addEvent(71,  1'b1, 4'd0, 4'd0);
    addEvent(184, 1'b1, 4'd0, 4'd0);
    applyReset(2);
    applyStimulus(2'b10, 1'b0);
    waitCyc(30);
    applyStimulus(2'b10, 1'b1);
    waitCyc(31);
    applyStimulus(2'b10, 1'b0);
    waitCyc(79);
    applyStimulus(2'b10, 1'b1);
    waitCyc(80);
    applyStimulus(2'b10, 1'b0);
    waitCyc(119);
    applyStimulus(2'b11, 1'b0);
    waitCyc(189);
    applyStimulus(2'b11, 1'b1);
    waitCyc(190);
    applyStimulus(2'b11, 1'b0);
    waitCyc(219);

    // Short reset mid-count in phase 11; counting resumes from phase 00.
    addProbe(0,   1, 0, 0, 0, 4'd3, 4'd0);
    addProbe(60,  0, 0, 1, 0, 4'd1, 4'd5);
    addProbe(120, 0, 1, 0, 1, 4'd0, 4'd0);
    addEvent(60,  1'b0, 4'd1, 4'd5);
    addEvent(120, 1'b1, 4'd0, 4'd0);
    applyReset(1);
    waitCyc(122);

    $display("[TB] stimulus complete");
    endReq = 1'b1;
  end

endmodule
